// File: rtl/adat_tx_mc.sv
`default_nettype none
// ============================================================================
// Module   : adat_tx_mc
// Purpose  : ADAT optical-format transmitter. Packs multichannel PCM words
//            from a 2-entry FIFO into 256-bit ADAT frames (normal or SMUX 2x)
//            and emits them NRZI-encoded, one frame bit per CLK_DIV clocks.
// Options  : ADAT_TX_UNDERRUN_REPEAT_EN - when defined, an underrun frame
//            repeats the slot data of the last successfully loaded frame;
//            otherwise underrun frames carry all-zero slots.
// Revision : 1.0 - initial release
// ============================================================================
module adat_tx_mc #(
    parameter int SAMPLE_W = 24,
    parameter int CHANNELS = 8,
    parameter int CLK_DIV  = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         enable_i,
    input  logic                         smux_i,
    input  logic [CHANNELS*SAMPLE_W-1:0] sample_i,
    input  logic                         sample_valid_i,
    output logic                         sample_ready_o,
    input  logic [3:0]                   user_i,
    output logic                         adat_o,
    output logic                         frame_start_o,
    output logic                         underrun_o
);

    localparam int         c_WORD_W   = CHANNELS * SAMPLE_W;
    localparam logic [3:0] c_DIV_LAST = 4'(CLK_DIV - 1);

    // Left-justify a sample into a 24-bit slot (MSB at bit 23).
    function automatic logic [23:0] f_just(input logic [SAMPLE_W-1:0] s);
        f_just = 24'(s) << (24 - SAMPLE_W);
    endfunction

    // Assemble a frame, first transmitted bit at [255].
    function automatic logic [255:0] f_build(input logic [3:0] u, input logic [191:0] slots);
        logic [255:0] f;
        int           pos;
        f          = '0;
        f[245]     = 1'b1;
        f[244:241] = u;
        f[240]     = 1'b1;
        for (int s = 0; s < 8; s++) begin
            for (int n = 0; n < 6; n++) begin
                pos              = 239 - s * 30 - n * 5;
                f[pos]           = 1'b1;
                f[pos - 1 -: 4]  = slots[s * 24 + 20 - 4 * n +: 4];
            end
        end
        f_build = f;
    endfunction

    logic [3:0]          r_div;
    logic [7:0]          r_bit;
    logic [255:0]        r_shift;
    logic                r_adat;
    logic                r_fs;
    logic                r_under;
    logic                r_ready;
    logic [1:0]          r_count;
    logic [c_WORD_W-1:0] r_mem [2];
`ifdef ADAT_TX_UNDERRUN_REPEAT_EN
    logic [191:0]        r_last;
    logic [191:0]        w_last_nxt;
`endif

    logic [3:0]          w_div_nxt;
    logic [7:0]          w_bit_nxt;
    logic [255:0]        w_shift_nxt;
    logic                w_adat_nxt;
    logic                w_fs_nxt;
    logic                w_under_nxt;
    logic                w_ready_nxt;
    logic [1:0]          w_count_nxt;
    logic [c_WORD_W-1:0] w_mem_nxt [2];

    logic                w_tick;
    logic                w_load;
    logic [1:0]          w_need;
    logic                w_have;
    logic [1:0]          w_pop;
    logic                w_push;
    logic [1:0]          w_count_left;
    logic [23:0]         w_ch_old [8];
    logic [23:0]         w_ch_new [8];
    logic [191:0]        w_slots;
    logic [191:0]        w_frame_slots;
    logic [255:0]        w_frame;

    assign w_tick = enable_i && (r_div == 4'd0);
    assign w_load = w_tick && (r_bit == 8'd0);
    assign w_need = smux_i ? 2'd2 : 2'd1;
    assign w_have = (r_count >= w_need);
    assign w_pop  = (w_load && w_have) ? w_need : 2'd0;
    assign w_push = sample_valid_i && r_ready;

    // Pad both FIFO entries out to 8 justified channels; absent channels are zero.
    for (genvar gi = 0; gi < 8; gi++) begin : g_chan
        if (gi < CHANNELS) begin : g_used
            assign w_ch_old[gi] = f_just(r_mem[0][gi * SAMPLE_W +: SAMPLE_W]);
            assign w_ch_new[gi] = f_just(r_mem[1][gi * SAMPLE_W +: SAMPLE_W]);
        end else begin : g_unused
            assign w_ch_old[gi] = 24'd0;
            assign w_ch_new[gi] = 24'd0;
        end
    end

    // Slot mapping: normal = channel k in slot k; SMUX = older/newer interleaved.
    always_comb begin
        w_slots = '0;
        for (int k = 0; k < 8; k++) begin
            if (!smux_i) begin
                w_slots[k * 24 +: 24] = w_ch_old[k];
            end else if (k % 2 == 1) begin
                w_slots[k * 24 +: 24] = w_ch_new[k / 2];
            end else begin
                w_slots[k * 24 +: 24] = w_ch_old[k / 2];
            end
        end
    end

    // Slot data actually sent: fresh data, or the underrun substitute.
    always_comb begin
`ifdef ADAT_TX_UNDERRUN_REPEAT_EN
        w_frame_slots = w_have ? w_slots : r_last;
`else
        w_frame_slots = w_have ? w_slots : 192'd0;
`endif
    end

    assign w_frame = f_build(user_i, w_frame_slots);

    // Bit timing, frame load and NRZI encoding.
    always_comb begin
        w_div_nxt   = r_div;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_adat_nxt  = r_adat;
        w_fs_nxt    = 1'b0;
        w_under_nxt = 1'b0;
        if (!enable_i) begin
            w_div_nxt = 4'd0;
            w_bit_nxt = 8'd0;
        end else begin
            w_div_nxt = (r_div == c_DIV_LAST) ? 4'd0 : r_div + 4'd1;
            if (w_tick) begin
                w_bit_nxt = r_bit + 8'd1;
                if (w_load) begin
                    w_shift_nxt = w_frame << 1;
                    w_adat_nxt  = r_adat ^ w_frame[255];
                    w_fs_nxt    = 1'b1;
                    w_under_nxt = !w_have;
                end else begin
                    w_shift_nxt = r_shift << 1;
                    w_adat_nxt  = r_adat ^ r_shift[255];
                end
            end
        end
    end

    // FIFO: entry 0 is the oldest; pops shift down, a push lands behind survivors.
    always_comb begin
        w_mem_nxt[0] = r_mem[0];
        w_mem_nxt[1] = r_mem[1];
        w_count_left = r_count - w_pop;
        if (w_pop == 2'd1) begin
            w_mem_nxt[0] = r_mem[1];
        end
        if (w_push) begin
            if (w_count_left == 2'd0) begin
                w_mem_nxt[0] = sample_i;
            end else begin
                w_mem_nxt[1] = sample_i;
            end
        end
        w_count_nxt = w_count_left + {1'b0, w_push};
        w_ready_nxt = (w_count_nxt != 2'd2);
    end

`ifdef ADAT_TX_UNDERRUN_REPEAT_EN
    // Remember the slot data of every successfully loaded frame.
    always_comb begin
        w_last_nxt = r_last;
        if (w_load && w_have) begin
            w_last_nxt = w_slots;
        end
    end
`endif

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_div    <= 4'd0;
            r_bit    <= 8'd0;
            r_shift  <= '0;
            r_adat   <= 1'b0;
            r_fs     <= 1'b0;
            r_under  <= 1'b0;
            r_ready  <= 1'b0;
            r_count  <= 2'd0;
            r_mem[0] <= '0;
            r_mem[1] <= '0;
`ifdef ADAT_TX_UNDERRUN_REPEAT_EN
            r_last   <= '0;
`endif
        end else begin
            r_div    <= w_div_nxt;
            r_bit    <= w_bit_nxt;
            r_shift  <= w_shift_nxt;
            r_adat   <= w_adat_nxt;
            r_fs     <= w_fs_nxt;
            r_under  <= w_under_nxt;
            r_ready  <= w_ready_nxt;
            r_count  <= w_count_nxt;
            r_mem[0] <= w_mem_nxt[0];
            r_mem[1] <= w_mem_nxt[1];
`ifdef ADAT_TX_UNDERRUN_REPEAT_EN
            r_last   <= w_last_nxt;
`endif
        end
    end

    assign sample_ready_o = r_ready;
    assign adat_o         = r_adat;
    assign frame_start_o  = r_fs;
    assign underrun_o     = r_under;

endmodule
`default_nettype wire

// File: tb/tb_adat_tx_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_adat_tx_mc
// Purpose  : Directed self-checking bench for adat_tx_mc (24-bit/8-channel and
//            16-bit/4-channel instances). Frames are NRZI-decoded and compared
//            with frames built from hand-chosen slot values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adat_tx_mc;

    localparam int c_DIV = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic         smux = 1'b0;
    logic [191:0] sample = '0;
    logic         valid = 1'b0;
    logic         ready;
    logic [3:0]   user = 4'd0;
    logic         adat, fs, under;

    logic         en16 = 1'b0;
    logic [63:0]  sample16 = '0;
    logic         valid16 = 1'b0;
    logic         ready16, adat16, fs16, under16;

    logic         sel = 1'b0;
    int           total = 0;
    int           bad = 0;
    int           frames_done = 0;
    int           under_cnt = 0;
    int           period_last = 0;
    logic [255:0] cap [16];

    always #5 clk = ~clk;

    adat_tx_mc #(.SAMPLE_W(24), .CHANNELS(8), .CLK_DIV(c_DIV)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .smux_i(smux),
        .sample_i(sample), .sample_valid_i(valid), .sample_ready_o(ready),
        .user_i(user), .adat_o(adat), .frame_start_o(fs), .underrun_o(under)
    );

    adat_tx_mc #(.SAMPLE_W(16), .CHANNELS(4), .CLK_DIV(c_DIV)) dut16 (
        .clk_i(clk), .rst_i(rst), .enable_i(en16), .smux_i(1'b0),
        .sample_i(sample16), .sample_valid_i(valid16), .sample_ready_o(ready16),
        .user_i(user), .adat_o(adat16), .frame_start_o(fs16), .underrun_o(under16)
    );

    wire cur_fs = sel ? fs16 : fs;

    // Reference frame: header then 48 groups of {1, nibble}, shifted in order.
    function automatic logic [255:0] exp_frame(input logic [3:0] u, input logic [191:0] sl);
        logic [255:0] f;
        logic [23:0]  s;
        f = 256'({10'b0, 1'b1, u, 1'b1});
        for (int k = 0; k < 8; k++) begin
            s = sl[k * 24 +: 24];
            for (int n = 5; n >= 0; n--) f = (f << 5) | 256'({1'b1, s[n * 4 +: 4]});
        end
        return f;
    endfunction

    // NRZI decoder / frame recorder for the selected instance.
    initial begin
        int cyc, fs_cyc, pos;
        logic a, a_last, act, have_fs, f, u, e;
        logic [255:0] fbuf;
        cyc = 0; fs_cyc = 0; pos = 0; a_last = 1'b0; act = 1'b0; have_fs = 1'b0; fbuf = '0;
        forever begin
            @(negedge clk);
            a = sel ? adat16 : adat;
            f = sel ? fs16 : fs;
            u = sel ? under16 : under;
            e = sel ? en16 : enable;
            if (!e) act = 1'b0;
            if (f) begin
                if (have_fs) period_last = cyc - fs_cyc;
                fs_cyc = cyc; have_fs = 1'b1; pos = 0; act = 1'b1;
            end
            if (act && ((cyc - fs_cyc) % c_DIV) == 0) begin
                fbuf[255 - pos] = a ^ a_last;
                pos++;
                if (pos == 256) begin
                    if (frames_done < 16) cap[frames_done] = fbuf;
                    frames_done++;
                    act = 1'b0;
                end
            end
            if (u) under_cnt++;
            a_last = a;
            cyc++;
        end
    end

    task automatic wait_fs();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cur_fs && n < 2000);
        if (!cur_fs) begin
            total++; bad++;
            $display("FAIL wait_fs: no frame_start within %0d cycles", n);
        end
    endtask

    task automatic wait_frames(input int target);
        int n;
        n = 0;
        while (frames_done < target && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (frames_done < target) begin
            total++; bad++;
            $display("FAIL wait_frames: got %0d frames, need %0d", frames_done, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (adat !== 1'b0)  begin bad++; $display("FAIL rst_adat: got %b exp 0", adat); end
        total++; if (fs !== 1'b0)    begin bad++; $display("FAIL rst_fs: got %b exp 0", fs); end
        total++; if (under !== 1'b0) begin bad++; $display("FAIL rst_under: got %b exp 0", under); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b exp 0", ready); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (ready !== 1'b1)   begin bad++; $display("FAIL post_rst_ready: got %b exp 1", ready); end
        total++; if (ready16 !== 1'b1) begin bad++; $display("FAIL post_rst_ready16: got %b exp 1", ready16); end
    endtask

    task automatic test_fifo_full();
        sample = 192'hABCDEF; valid = 1'b1;
        @(negedge clk);
        sample = {24'hFEDCBA, 120'h0, 24'h123456, 24'h0};
        @(negedge clk);
        valid = 1'b0;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL fifo_full_ready: got %b exp 0", ready); end
        sample = {192{1'b1}}; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic test_normal();
        int base, ub;
        logic [191:0] w1, w2, w3, ur;
        w1 = 192'hABCDEF;
        w2 = {24'hFEDCBA, 120'h0, 24'h123456, 24'h0};
        w3 = {96'h0, 24'h000001, 24'h800000, 24'h0, 24'h7FFFFF};
`ifdef ADAT_TX_UNDERRUN_REPEAT_EN
        ur = w3;
`else
        ur = '0;
`endif
        base = frames_done; ub = under_cnt;
        user = 4'b1010; smux = 1'b0; enable = 1'b1;
        wait_fs();
        user = 4'b0101;
        repeat (511) @(negedge clk);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL ready_before_pushpop: got %b exp 1", ready); end
        sample = w3; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        total++; if (fs !== 1'b1) begin bad++; $display("FAIL pushpop_load_fs: got %b exp 1", fs); end
        wait_frames(base + 4);
        enable = 1'b0;
        total++; if (cap[base] !== exp_frame(4'b1010, w1))
            begin bad++; $display("FAIL frame_w1: got %h exp %h", cap[base], exp_frame(4'b1010, w1)); end
        total++; if (cap[base+1] !== exp_frame(4'b0101, w2))
            begin bad++; $display("FAIL frame_w2: got %h exp %h", cap[base+1], exp_frame(4'b0101, w2)); end
        total++; if (cap[base+2] !== exp_frame(4'b0101, w3))
            begin bad++; $display("FAIL frame_w3_order: got %h exp %h", cap[base+2], exp_frame(4'b0101, w3)); end
        total++; if (cap[base+3] !== exp_frame(4'b0101, ur))
            begin bad++; $display("FAIL frame_underrun: got %h exp %h", cap[base+3], exp_frame(4'b0101, ur)); end
        total++; if (period_last !== 512) begin bad++; $display("FAIL fs_period: got %0d exp 512", period_last); end
        total++; if (under_cnt - ub !== 1) begin bad++; $display("FAIL underrun_count: got %0d exp 1", under_cnt - ub); end
    endtask

    task automatic test_smux();
        int base, ub;
        logic [191:0] a, b, sl, ur;
        a  = {72'h0, 24'h999999, 24'h0, 24'h0, 24'h333333, 24'h111111};
        b  = {96'h0, 24'h777777, 24'h0, 24'h444444, 24'h222222};
        sl = {24'h777777, 24'h0, 24'h0, 24'h0, 24'h444444, 24'h333333, 24'h222222, 24'h111111};
`ifdef ADAT_TX_UNDERRUN_REPEAT_EN
        ur = sl;
`else
        ur = '0;
`endif
        sample = a; valid = 1'b1;
        @(negedge clk);
        sample = b;
        @(negedge clk);
        valid = 1'b0;
        base = frames_done; ub = under_cnt;
        smux = 1'b1; user = 4'b0011; enable = 1'b1;
        wait_fs();
        smux = 1'b0;
        wait_frames(base + 2);
        enable = 1'b0;
        total++; if (cap[base] !== exp_frame(4'b0011, sl))
            begin bad++; $display("FAIL smux_frame: got %h exp %h", cap[base], exp_frame(4'b0011, sl)); end
        total++; if (cap[base+1] !== exp_frame(4'b0011, ur))
            begin bad++; $display("FAIL smux_two_popped: got %h exp %h", cap[base+1], exp_frame(4'b0011, ur)); end
        total++; if (under_cnt - ub !== 1) begin bad++; $display("FAIL smux_underrun_count: got %0d exp 1", under_cnt - ub); end
    endtask

    task automatic test_reset_midframe();
        sample = 192'h5A5A5A; valid = 1'b1;
        @(negedge clk);
        sample = 192'hC3C3C3;
        @(negedge clk);
        valid = 1'b0;
        enable = 1'b1;
        wait_fs();
        repeat (200) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (adat !== 1'b0)  begin bad++; $display("FAIL midrst_adat: got %b exp 0", adat); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL midrst_ready: got %b exp 0", ready); end
        total++; if (fs !== 1'b0)    begin bad++; $display("FAIL midrst_fs: got %b exp 0", fs); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (fs !== 1'b1)    begin bad++; $display("FAIL rst_first_fs: got %b exp 1", fs); end
        total++; if (under !== 1'b1) begin bad++; $display("FAIL rst_fifo_empty_under: got %b exp 1", under); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b exp 1", ready); end
        enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_w16();
        int base, ub;
        logic [191:0] sl;
        sl = {96'h0, 24'h800100, 24'h0, 24'h0, 24'hFFFF00};
        sel = 1'b1;
        user = 4'b1100;
        sample16 = {16'h8001, 16'h0, 16'h0, 16'hFFFF}; valid16 = 1'b1;
        @(negedge clk);
        valid16 = 1'b0;
        base = frames_done; ub = under_cnt;
        en16 = 1'b1;
        wait_fs();
        wait_frames(base + 1);
        en16 = 1'b0;
        total++; if (cap[base] !== exp_frame(4'b1100, sl))
            begin bad++; $display("FAIL w16_frame: got %h exp %h", cap[base], exp_frame(4'b1100, sl)); end
        total++; if (under_cnt - ub !== 0) begin bad++; $display("FAIL w16_underrun: got %0d exp 0", under_cnt - ub); end
    endtask

    initial begin
        test_reset();
        test_fifo_full();
        test_normal();
        test_smux();
        test_reset_midframe();
        test_w16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
